// File: rtl/lift_pkg.sv
// lift_pkg: shared definitions for the elevator call scheduler.
//   lift_state_e : scheduler FSM states
//   floor_w()    : index width for a count of floors (min 1 bit)
//   DEF_*        : default timing / size constants
package lift_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE_UP   = 2'd1,
      MOVE_DOWN = 2'd2,
      DOOR_OPEN = 2'd3
   } lift_state_e;

   localparam int DEF_NUM_FLOORS = 4;
   localparam int DEF_TICK_DIV   = 50_000_000;
   localparam int DEF_MOVE_TICKS = 2;
   localparam int DEF_DOOR_TICKS = 3;

   function automatic int floor_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/elevator_call_scheduler_tick_prescaler.sv
// tick_prescaler: emits a one-cycle tick every TICK_DIV clocks.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   clr   : restart the count so the next tick is TICK_DIV cycles away
//   tick  : one-cycle pulse
module tick_prescaler #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);
   localparam int CW = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (clr) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: SCAN / collective call scheduler.
// Latches floor calls, keeps travelling while calls remain ahead, reverses
// otherwise, moves one floor per MOVE_TICKS ticks and dwells DOOR_TICKS ticks.
//   clk, rst_n    : clock, synchronous active-low reset
//   call_req      : per-floor call inputs, any high cycle latches
//   cur_floor     : current floor (binary), cur_floor_oh : one-hot
//   pending       : latched unserved calls
//   moving        : car travelling, dir_up : travel / last direction
//   door_open     : door dwell, busy : not idle or calls pending
module elevator_call_scheduler
   import lift_pkg::*;
#(
   parameter int NUM_FLOORS = DEF_NUM_FLOORS,
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int MOVE_TICKS = DEF_MOVE_TICKS,
   parameter int DOOR_TICKS = DEF_DOOR_TICKS,
   localparam int FW        = floor_w(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] call_req,
   output logic [FW-1:0]         cur_floor,
   output logic [NUM_FLOORS-1:0] cur_floor_oh,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  moving,
   output logic                  dir_up,
   output logic                  door_open,
   output logic                  busy
);
   localparam int PMAX = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
   localparam int PW   = floor_w(PMAX + 1);
   localparam logic [PW-1:0] MOVE_LAST = PW'(MOVE_TICKS - 1);
   localparam logic [PW-1:0] DOOR_LAST = PW'(DOOR_TICKS - 1);
   localparam logic [FW-1:0] TOP       = FW'(NUM_FLOORS - 1);

   lift_state_e           state_q, state_d;
   logic [FW-1:0]         floor_q, floor_d;
   logic [NUM_FLOORS-1:0] pend_q, pend_d, oh_q, oh_d, clr_mask;
   logic                  dir_q, dir_d;
   logic [PW-1:0]         ph_q, ph_d;
   logic                  moving_q, door_q, busy_q;
   logic                  tick, above, below, here;

   function automatic logic any_above(input logic [NUM_FLOORS-1:0] p,
                                      input logic [FW-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (FW'(i) > f) r = r | p[i];
      return r;
   endfunction

   function automatic logic any_below(input logic [NUM_FLOORS-1:0] p,
                                      input logic [FW-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (FW'(i) < f) r = r | p[i];
      return r;
   endfunction

   // Restarting the prescaler on every state change makes each phase an
   // exact multiple of TICK_DIV. A MOVE that continues past a floor needs no
   // restart: the prescaler wraps on the same tick that steps the floor.
   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_d != state_q),
      .tick  (tick)
   );

   assign above = any_above(pend_q, floor_q);
   assign below = any_below(pend_q, floor_q);
   assign here  = pend_q[floor_q];

   always_comb begin
      state_d = state_q;
      floor_d = floor_q;
      dir_d   = dir_q;
      ph_d    = ph_q;
      case (state_q)
         IDLE: begin
            if (here) state_d = DOOR_OPEN;
            else if (above && (dir_q || !below)) begin
               state_d = MOVE_UP;
               dir_d   = 1'b1;
            end else if (below) begin
               state_d = MOVE_DOWN;
               dir_d   = 1'b0;
            end
         end
         // Arrival decisions look at pend_q, so a call landing on the
         // arrival edge is only seen by the following evaluation.
         MOVE_UP: if (tick) begin
            if (ph_q == MOVE_LAST) begin
               ph_d = '0;
               if (floor_q == TOP) state_d = IDLE;
               else begin
                  floor_d = floor_q + 1'b1;
                  if (pend_q[floor_d])                state_d = DOOR_OPEN;
                  else if (!any_above(pend_q, floor_d)) state_d = IDLE;
               end
            end else ph_d = ph_q + 1'b1;
         end
         MOVE_DOWN: if (tick) begin
            if (ph_q == MOVE_LAST) begin
               ph_d = '0;
               if (floor_q == '0) state_d = IDLE;
               else begin
                  floor_d = floor_q - 1'b1;
                  if (pend_q[floor_d])                state_d = DOOR_OPEN;
                  else if (!any_below(pend_q, floor_d)) state_d = IDLE;
               end
            end else ph_d = ph_q + 1'b1;
         end
         DOOR_OPEN: if (tick) begin
            if (ph_q == DOOR_LAST) state_d = IDLE;
            else                   ph_d    = ph_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) ph_d = '0;
   end

   // Current-floor calls are swallowed from door entry through the last
   // dwell cycle, so they never show up in pending.
   always_comb begin
      for (int i = 0; i < NUM_FLOORS; i++) oh_d[i] = (floor_d == FW'(i));
      clr_mask = (state_q == DOOR_OPEN || state_d == DOOR_OPEN) ? oh_d : '0;
      pend_d   = (pend_q | call_req) & ~clr_mask;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         floor_q  <= '0;
         oh_q     <= NUM_FLOORS'(1);
         pend_q   <= '0;
         dir_q    <= 1'b1;
         ph_q     <= '0;
         moving_q <= 1'b0;
         door_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         floor_q  <= floor_d;
         oh_q     <= oh_d;
         pend_q   <= pend_d;
         dir_q    <= dir_d;
         ph_q     <= ph_d;
         moving_q <= (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
         door_q   <= (state_d == DOOR_OPEN);
         busy_q   <= (state_d != IDLE) || (|pend_d);
      end
   end

   assign cur_floor    = floor_q;
   assign cur_floor_oh = oh_q;
   assign pending      = pend_q;
   assign moving       = moving_q;
   assign dir_up       = dir_q;
   assign door_open    = door_q;
   assign busy         = busy_q;
endmodule
